// File: rtl/debounce_bank_if.sv
// Debouncer bank signal bundle: raw inputs and enable in, debounced level and event pulses out.
interface debounce_bank_if #(
  parameter int N = 4
) ();
  logic         enable;
  logic [N-1:0] sig_i;
  logic [N-1:0] sig_o;
  logic [N-1:0] rise_o;
  logic [N-1:0] fall_o;
  logic [N-1:0] long_o;

  modport master (
    output enable, sig_i,
    input  sig_o, rise_o, fall_o, long_o
  );

  modport slave (
    input  enable, sig_i,
    output sig_o, rise_o, fall_o, long_o
  );
endinterface

// File: rtl/debounce_bank.sv
// N-channel push-button debouncer: per-channel polarity, 2-FF synchroniser, stability counter,
// registered rise/fall pulses and a one-shot long-press pulse.
module debounce_bank #(
  parameter int           N             = 4,
  parameter int           CLK_PERIOD_ns = 20,
  parameter int           DEBOUNCE_ns   = 30_000_000,
  parameter int           LONG_ns       = 1_000_000_000,
  parameter logic [N-1:0] INVERT_MASK   = '0
) (
  input  logic            clk,
  input  logic            resetn,
  debounce_bank_if.slave  db_if
);

  localparam int DB_CYC = DEBOUNCE_ns / CLK_PERIOD_ns;
  localparam int LP_CYC = LONG_ns / CLK_PERIOD_ns;
  localparam int DBW    = $clog2(DB_CYC + 1);
  localparam int LPW    = $clog2(LP_CYC + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
  localparam logic [LPW-1:0] LP_LAST = LPW'(LP_CYC - 1);
  localparam logic [LPW-1:0] LP_MAX  = LPW'(LP_CYC);

  logic [N-1:0] w_level;
  logic [N-1:0] w_rise;
  logic [N-1:0] w_fall;
  logic [N-1:0] w_long;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic [1:0]     r_sync;
      logic [DBW-1:0] r_db_cnt;
      logic [LPW-1:0] r_lp_cnt;
      logic           r_level;
      logic           r_rise;
      logic           r_fall;
      logic           r_long;
      logic           w_x;
      logic           w_s;
      logic           w_qualify;

      assign w_x = db_if.sig_i[gi] ^ INVERT_MASK[gi];
      assign w_s = r_sync[1];
      // Synchronised input has disagreed with the level for DB_CYC enabled cycles.
      assign w_qualify = (w_s != r_level) && (r_db_cnt == DB_LAST);

      // The synchroniser keeps running while disabled so the input is fresh when enable returns.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[0], w_x};
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_db_cnt <= '0;
          r_lp_cnt <= '0;
          r_level  <= 1'b0;
          r_rise   <= 1'b0;
          r_fall   <= 1'b0;
          r_long   <= 1'b0;
        end else if (!db_if.enable) begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          r_long <= 1'b0;
        end else begin
          r_rise <= w_qualify & w_s;
          r_fall <= w_qualify & ~w_s;
          // A release qualifying on the threshold cycle suppresses the long-press pulse.
          r_long <= r_level & (r_lp_cnt == LP_LAST) & ~w_qualify;

          if (w_s == r_level) begin
            r_db_cnt <= '0;
          end else if (w_qualify) begin
            r_level  <= w_s;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + DBW'(1);
          end

          if (!r_level) begin
            r_lp_cnt <= '0;
          end else if (r_lp_cnt != LP_MAX) begin
            r_lp_cnt <= r_lp_cnt + LPW'(1);
          end
        end
      end

      assign w_level[gi] = r_level;
      assign w_rise[gi]  = r_rise;
      assign w_fall[gi]  = r_fall;
      assign w_long[gi]  = r_long;
    end
  endgenerate

  assign db_if.sig_o  = w_level;
  assign db_if.rise_o = w_rise;
  assign db_if.fall_o = w_fall;
  assign db_if.long_o = w_long;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (DB_CYC=5, LP_CYC=20, channel 3 active-low).
module tb_debounce_bank;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  always #10 clk = ~clk;

  debounce_bank_if #(.N(4)) dbif ();

  debounce_bank #(
    .N            (4),
    .CLK_PERIOD_ns(20),
    .DEBOUNCE_ns  (100),
    .LONG_ns      (400),
    .INVERT_MASK  (4'b1000)
  ) u_dut (
    .clk   (clk),
    .resetn(resetn),
    .db_if (dbif)
  );

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {sig_o, rise_o, fall_o, long_o} of one channel.
  function automatic logic [3:0] ch(input int c);
    return {dbif.sig_o[c], dbif.rise_o[c], dbif.fall_o[c], dbif.long_o[c]};
  endfunction

  function automatic logic [15:0] all_out();
    return {dbif.sig_o, dbif.rise_o, dbif.fall_o, dbif.long_o};
  endfunction

  task automatic test_reset();
    dbif.enable = 1'b1;
    dbif.sig_i  = 4'b1000;
    resetn      = 1'b0;
    repeat (3) step();
    total++;
    if (all_out() !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=0000", all_out());
    end
    resetn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++;
      if (all_out() !== 16'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%h want=0000", i, all_out());
      end
    end
    $display("scenario reset done total=%0d", total);
  endtask

  task automatic test_clean_rise();
    logic [3:0] exp;
    dbif.sig_i[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = (i == 7) ? 4'b1100 : (i == 8) ? 4'b1000 : 4'b0000;
      total++;
      if (ch(0) !== exp) begin
        bad++;
        $display("FAIL clean_rise cyc=%0d got=%b want=%b", i, ch(0), exp);
      end
    end
    dbif.sig_i[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = (i < 7) ? 4'b1000 : (i == 7) ? 4'b0010 : 4'b0000;
      total++;
      if (ch(0) !== exp) begin
        bad++;
        $display("FAIL clean_fall cyc=%0d got=%b want=%b", i, ch(0), exp);
      end
    end
    $display("scenario clean_rise done total=%0d", total);
  endtask

  task automatic test_bounce();
    logic [3:0] exp;
    for (int seg = 0; seg < 4; seg++) begin
      dbif.sig_i[1] = (seg % 2 == 0);
      for (int i = 1; i <= 3; i++) begin
        step();
        total++;
        if (ch(1) !== 4'b0000) begin
          bad++;
          $display("FAIL bounce seg=%0d cyc=%0d got=%b want=0000", seg, i, ch(1));
        end
      end
    end
    dbif.sig_i[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = (i == 7) ? 4'b1100 : (i == 8) ? 4'b1000 : 4'b0000;
      total++;
      if (ch(1) !== exp) begin
        bad++;
        $display("FAIL bounce_settle cyc=%0d got=%b want=%b", i, ch(1), exp);
      end
    end
    $display("scenario bounce done total=%0d", total);
  endtask

  task automatic test_long_press();
    logic [3:0] exp;
    dbif.sig_i[2] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp = (i == 7) ? 4'b1100 : 4'b0000;
      total++;
      if (ch(2) !== exp) begin
        bad++;
        $display("FAIL long_rise cyc=%0d got=%b want=%b", i, ch(2), exp);
      end
    end
    for (int i = 1; i <= 33; i++) begin
      step();
      exp = (i == 20) ? 4'b1001 : 4'b1000;
      total++;
      if (ch(2) !== exp) begin
        bad++;
        $display("FAIL long_hold cyc=%0d got=%b want=%b", i, ch(2), exp);
      end
    end
    dbif.sig_i[2] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = (i < 7) ? 4'b1000 : (i == 7) ? 4'b0010 : 4'b0000;
      total++;
      if (ch(2) !== exp) begin
        bad++;
        $display("FAIL long_release cyc=%0d got=%b want=%b", i, ch(2), exp);
      end
    end
    $display("scenario long_press done total=%0d", total);
  endtask

  task automatic test_release_at_threshold();
    logic [3:0] exp;
    dbif.sig_i[2] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp = (i == 7) ? 4'b1100 : (i > 7) ? 4'b1000 : 4'b0000;
      total++;
      if (ch(2) !== exp) begin
        bad++;
        $display("FAIL thresh_press cyc=%0d got=%b want=%b", i, ch(2), exp);
      end
    end
    // Fall qualifies on the same edge the hold count reaches LP_CYC.
    dbif.sig_i[2] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i < 7) ? 4'b1000 : (i == 7) ? 4'b0010 : 4'b0000;
      total++;
      if (ch(2) !== exp) begin
        bad++;
        $display("FAIL thresh_release cyc=%0d got=%b want=%b", i, ch(2), exp);
      end
    end
    $display("scenario release_at_threshold done total=%0d", total);
  endtask

  task automatic test_inverted();
    logic [3:0] exp;
    dbif.sig_i[3] = 1'b0;
    resetn        = 1'b0;
    repeat (2) step();
    total++;
    if (all_out() !== 16'h0) begin
      bad++;
      $display("FAIL inv_reset got=%h want=0000", all_out());
    end
    resetn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = (i == 7) ? 4'b1100 : (i == 8) ? 4'b1000 : 4'b0000;
      total++;
      if (ch(3) !== exp) begin
        bad++;
        $display("FAIL inv_rise cyc=%0d got=%b want=%b", i, ch(3), exp);
      end
    end
    dbif.sig_i[3] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = (i < 7) ? 4'b1000 : (i == 7) ? 4'b0010 : 4'b0000;
      total++;
      if (ch(3) !== exp) begin
        bad++;
        $display("FAIL inv_fall cyc=%0d got=%b want=%b", i, ch(3), exp);
      end
    end
    $display("scenario inverted done total=%0d", total);
  endtask

  task automatic test_enable_freeze();
    logic [3:0] exp;
    dbif.sig_i[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      total++;
      if (ch(0) !== 4'b0000) begin
        bad++;
        $display("FAIL en_count cyc=%0d got=%b want=0000", i, ch(0));
      end
    end
    dbif.enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++;
      if (ch(0) !== 4'b0000) begin
        bad++;
        $display("FAIL en_frozen cyc=%0d got=%b want=0000", i, ch(0));
      end
    end
    dbif.enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = (i == 2) ? 4'b1100 : (i == 3) ? 4'b1000 : 4'b0000;
      total++;
      if (ch(0) !== exp) begin
        bad++;
        $display("FAIL en_resume cyc=%0d got=%b want=%b", i, ch(0), exp);
      end
    end
    $display("scenario enable_freeze done total=%0d", total);
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] exp;
    // Hold count is 1 on entry; bring it to 15.
    for (int i = 1; i <= 14; i++) begin
      step();
      total++;
      if (ch(0) !== 4'b1000) begin
        bad++;
        $display("FAIL mid_hold cyc=%0d got=%b want=1000", i, ch(0));
      end
    end
    resetn = 1'b0;
    #1;
    total++;
    if (all_out() !== 16'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0000", all_out());
    end
    repeat (2) step();
    resetn = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      step();
      exp = (i < 7) ? 4'b0000 : (i == 7) ? 4'b1100 : (i == 27) ? 4'b1001 : 4'b1000;
      total++;
      if (ch(0) !== exp) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got=%b want=%b", i, ch(0), exp);
      end
    end
    $display("scenario reset_mid_hold done total=%0d", total);
  endtask

  task automatic test_simultaneous();
    logic [3:0] obs;
    logic [3:0] exp;
    dbif.sig_i[1:0] = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      step();
      obs = {dbif.sig_o[1:0], dbif.fall_o[1:0]};
      exp = (i < 7) ? 4'b1100 : (i == 7) ? 4'b0011 : 4'b0000;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL simul_fall cyc=%0d got=%b want=%b", i, obs, exp);
      end
    end
    $display("scenario simultaneous done total=%0d", total);
  endtask

  initial begin
    dbif.enable = 1'b1;
    dbif.sig_i  = 4'b1000;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_long_press();
    test_release_at_threshold();
    test_inverted();
    test_enable_freeze();
    test_reset_mid_hold();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
